wbm_copy: RTL

//   Wishbone classic initiator that copies a block of 32-bit words from a source
//   to a destination address, one word per read/write pair. Sits on the system
//   bus as a master beside the CPU; drives monitor/boot RAM slaves and SDRAM

---
 rtl/wbm_copy.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/wbm_copy.sv
// wbm_copy: Wishbone classic initiator that copies a block of 32-bit words
// from src_adr to dst_adr, one read/write pair per word, with one idle bus
// cycle after every ack so registered-ack slaves never see back-to-back stb.
// Optional feature macro: CFG_WBM_COPY_TIMEOUT_EN (per-access ack timeout;
// when undefined the master waits for ack indefinitely and error stays 0).
module wbm_copy #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [31:0]      src_adr,
  input  logic [31:0]      dst_adr,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_done,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic [31:0]      wbm_dat_i,
  output logic [3:0]       wbm_sel_o,
  output logic             wbm_stb_o,
  output logic             wbm_cyc_o,
  output logic             wbm_we_o,
  input  logic             wbm_ack_i
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_RGAP = 3'd2,
    ST_WR   = 3'd3,
    ST_WGAP = 3'd4,
    ST_FIN  = 3'd5
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [31:0]      src_ptr_r, src_ptr_nxt_s;
  logic [31:0]      dst_ptr_r, dst_ptr_nxt_s;
  logic [CNT_W-1:0] count_r, count_nxt_s;
  logic [CNT_W-1:0] words_done_r, words_done_nxt_s;
  logic [31:0]      dat_r, dat_nxt_s;
  logic             error_r, error_nxt_s;
  logic [31:0]      adr_r, adr_nxt_s;
  logic             stb_r, stb_nxt_s;
  logic             we_r, we_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic             done_r, done_nxt_s;
  logic             bus_phase_s;
  logic             timeout_s;
  logic             unused_s;

  // Only RD and WR drive a bus access; ack outside them is ignored.
  assign bus_phase_s = (state_r == ST_RD) || (state_r == ST_WR);

`ifdef CFG_WBM_COPY_TIMEOUT_EN
  localparam int               TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] tmo_cnt_r;
  logic             enter_bus_s;

  assign enter_bus_s = (state_nxt_s != state_r) &&
                       ((state_nxt_s == ST_RD) || (state_nxt_s == ST_WR));
  // Abort on the last unacked cycle so stb is high exactly TIMEOUT cycles.
  assign timeout_s   = bus_phase_s && !wbm_ack_i && (tmo_cnt_r == TMO_LAST);
  assign unused_s    = ^{src_adr[1:0], dst_adr[1:0]};

  // Count unacked strobe cycles, restarting at every new bus access.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if (enter_bus_s) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if (bus_phase_s && !wbm_ack_i) begin
      tmo_cnt_r <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end
`else
  localparam logic [31:0] TMO_L = 32'(TIMEOUT);

  assign timeout_s = 1'b0;
  assign unused_s  = ^{src_adr[1:0], dst_adr[1:0], TMO_L};
`endif

  // Next-state logic; count==0 passes through WGAP so no bus access occurs.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (count == {CNT_W{1'b0}}) begin
            state_nxt_s = ST_WGAP;
          end else begin
            state_nxt_s = ST_RD;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RD: begin
        if (timeout_s) begin
          state_nxt_s = ST_FIN;
        end else if (wbm_ack_i) begin
          state_nxt_s = ST_RGAP;
        end else begin
          state_nxt_s = ST_RD;
        end
      end
      ST_RGAP: state_nxt_s = ST_WR;
      ST_WR: begin
        if (timeout_s) begin
          state_nxt_s = ST_FIN;
        end else if (wbm_ack_i) begin
          state_nxt_s = ST_WGAP;
        end else begin
          state_nxt_s = ST_WR;
        end
      end
      ST_WGAP: begin
        if (words_done_r != count_r) begin
          state_nxt_s = ST_RD;
        end else begin
          state_nxt_s = ST_FIN;
        end
      end
      ST_FIN:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Datapath updates: parameter latch on accepted start, pointer/data on ack.
  always_comb begin
    src_ptr_nxt_s    = src_ptr_r;
    dst_ptr_nxt_s    = dst_ptr_r;
    count_nxt_s      = count_r;
    words_done_nxt_s = words_done_r;
    dat_nxt_s        = dat_r;
    error_nxt_s      = error_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          src_ptr_nxt_s    = {src_adr[31:2], 2'b00};
          dst_ptr_nxt_s    = {dst_adr[31:2], 2'b00};
          count_nxt_s      = count;
          words_done_nxt_s = {CNT_W{1'b0}};
          error_nxt_s      = 1'b0;
        end else begin
          error_nxt_s      = error_r;
        end
      end
      ST_RD: begin
        if (timeout_s) begin
          error_nxt_s   = 1'b1;
        end else if (wbm_ack_i) begin
          dat_nxt_s     = wbm_dat_i;
          src_ptr_nxt_s = src_ptr_r + 32'd4;
        end else begin
          dat_nxt_s     = dat_r;
        end
      end
      ST_WR: begin
        if (timeout_s) begin
          error_nxt_s      = 1'b1;
        end else if (wbm_ack_i) begin
          dst_ptr_nxt_s    = dst_ptr_r + 32'd4;
          words_done_nxt_s = words_done_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          words_done_nxt_s = words_done_r;
        end
      end
      default: begin
        error_nxt_s = error_r;
      end
    endcase
  end

  // Bus and status outputs for the coming cycle, decoded from the next state.
  always_comb begin
    stb_nxt_s  = (state_nxt_s == ST_RD) || (state_nxt_s == ST_WR);
    we_nxt_s   = (state_nxt_s == ST_WR);
    busy_nxt_s = (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_FIN);
    done_nxt_s = (state_nxt_s == ST_FIN);
    case (state_nxt_s)
      ST_RD:   adr_nxt_s = src_ptr_nxt_s;
      ST_WR:   adr_nxt_s = dst_ptr_nxt_s;
      default: adr_nxt_s = 32'h0000_0000;
    endcase
  end

  // State and registered outputs; reset drops cyc/stb immediately.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_r <= ST_IDLE;
      stb_r   <= 1'b0;
      we_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      adr_r   <= 32'h0000_0000;
    end else begin
      state_r <= state_nxt_s;
      stb_r   <= stb_nxt_s;
      we_r    <= we_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
      adr_r   <= adr_nxt_s;
    end
  end

  // Copy parameters, word pointers, data buffer and status counters.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      src_ptr_r    <= 32'h0000_0000;
      dst_ptr_r    <= 32'h0000_0000;
      count_r      <= {CNT_W{1'b0}};
      words_done_r <= {CNT_W{1'b0}};
      dat_r        <= 32'h0000_0000;
      error_r      <= 1'b0;
    end else begin
      src_ptr_r    <= src_ptr_nxt_s;
      dst_ptr_r    <= dst_ptr_nxt_s;
      count_r      <= count_nxt_s;
      words_done_r <= words_done_nxt_s;
      dat_r        <= dat_nxt_s;
      error_r      <= error_nxt_s;
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign error      = error_r;
  assign words_done = words_done_r;
  assign wbm_adr_o  = adr_r;
  assign wbm_dat_o  = dat_r;
  assign wbm_sel_o  = 4'hF;
  assign wbm_stb_o  = stb_r;
  assign wbm_cyc_o  = stb_r;
  assign wbm_we_o   = we_r;

endmodule
